// File: rtl/iob_bus_arbiter.sv
// iob_bus_arbiter: two-requester arbiter for a shared IOb native memory port.
// m0 is the instruction bus and m1 is the data bus. Only one transaction can
// be outstanding at a time. The address path has zero latency, and read data
// is routed back only to the requester that owns the current transaction.
module iob_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRIO    = 0,
    localparam int WSTRB_W = DATA_W / 8,
    localparam int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W,
    localparam int RESP_W  = DATA_W + 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic [REQ_W-1:0]  m0_req_i,
    output logic [RESP_W-1:0] m0_resp_o,
    input  logic [REQ_W-1:0]  m1_req_i,
    output logic [RESP_W-1:0] m1_resp_o,
    output logic [REQ_W-1:0]  s_req_o,
    input  logic [RESP_W-1:0] s_resp_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              last_q, last_d;

    logic              m0_av, m1_av;
    logic              s_ready, s_rvalid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        winner;
    logic [1:0]        cur_owner;
    logic [REQ_W-1:0]  fwd_req;
    logic [RESP_W-1:0] owner_resp;
    logic              accept;
    logic              is_write;

    assign m0_av    = m0_req_i[REQ_W-1];
    assign m1_av    = m1_req_i[REQ_W-1];
    assign s_ready  = s_resp_i[0];
    assign s_rvalid = s_resp_i[1];
    assign s_rdata  = s_resp_i[RESP_W-1:2];

    // The state, owner and last-grant registers. Reset makes m1 the last
    // requester granted, so the first tie is won by m0.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            owner_q <= 2'b00;
            last_q  <= 1'b1;
        end else if (cke_i) begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Choose a winner among the requesters that are raising avalid.
    // In round-robin mode (last_q = 1 means m1 was granted last), a tie goes
    // to the requester that was not granted last.
    always_comb begin
        winner = 2'b00;
        if (PRIO == 1) begin
            if (m1_av) begin
                winner = 2'b10;
            end else if (m0_av) begin
                winner = 2'b01;
            end
        end else begin
            if (m0_av && m1_av) begin
                winner = last_q ? 2'b01 : 2'b10;
            end else if (m0_av) begin
                winner = 2'b01;
            end else if (m1_av) begin
                winner = 2'b10;
            end
        end
    end

    // Next-state logic, request forwarding and response selection.
    // In IDLE the winner owns the bus for this cycle. In every other state
    // the latched owner keeps the bus until its transaction completes.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        owner_resp = '0;
        cur_owner  = (state_q == IDLE) ? winner : owner_q;

        fwd_req = '0;
        if (cur_owner[0]) begin
            fwd_req = m0_req_i;
        end else if (cur_owner[1]) begin
            fwd_req = m1_req_i;
        end
        if (state_q == RDATA) begin
            fwd_req[REQ_W-1] = 1'b0;
        end

        accept   = fwd_req[REQ_W-1] & s_ready;
        is_write = |fwd_req[WSTRB_W-1:0];

        case (state_q)
            IDLE: begin
                owner_resp = {{DATA_W{1'b0}}, 1'b0, s_ready};
                if (cur_owner != 2'b00) begin
                    owner_d = cur_owner;
                    if (accept) begin
                        state_d = is_write ? IDLE : RDATA;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                owner_resp = {{DATA_W{1'b0}}, 1'b0, s_ready};
                if (!fwd_req[REQ_W-1]) begin
                    state_d = IDLE;
                end else if (s_ready) begin
                    state_d = is_write ? IDLE : RDATA;
                end
            end
            RDATA: begin
                if (s_rvalid) begin
                    owner_resp = {s_rdata, 1'b1, 1'b0};
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            last_d = cur_owner[1];
        end
        if (state_d == IDLE) begin
            owner_d = 2'b00;
        end
    end

    // Drive the outputs. Every output is held at zero while reset is asserted,
    // even if requests are present on the inputs.
    always_comb begin
        s_req_o   = '0;
        m0_resp_o = '0;
        m1_resp_o = '0;
        grant_o   = 2'b00;
        busy_o    = 1'b0;
        if (arst_n_i) begin
            s_req_o   = fwd_req;
            m0_resp_o = cur_owner[0] ? owner_resp : '0;
            m1_resp_o = cur_owner[1] ? owner_resp : '0;
            grant_o   = cur_owner;
            busy_o    = (state_q != IDLE);
        end
    end

endmodule
